// File: rtl/watch_pkg.sv
// Shared watch constants: clock frequency, ms-divider sizing, and the
// state encodings for the Adjust hold FSM and the downstream counter FSM.
package watch_pkg;

   localparam int unsigned CLK_HZ_DEF = 27_000_000;

   function automatic int unsigned ms_div_w(input int unsigned clk_hz);
      int unsigned div;
      div = clk_hz / 1000;
      return (div > 1) ? $clog2(div) : 1;
   endfunction

   localparam int unsigned MS_DIV_W = ms_div_w(CLK_HZ_DEF);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_HOLD = 2'd1,
      REPEAT    = 2'd2
   } hold_state_e;

   typedef enum logic [1:0] {
      CNT_WATCH       = 2'd0,
      CNT_CHRONO_STOP = 2'd1,
      CNT_CHRONO_RUN  = 2'd2,
      CNT_CHANGE      = 2'd3
   } cnt_state_e;

endpackage

// File: rtl/watch_input_ctrl_if.sv
// Button pins in, command pulses out; master is the board/FSM side,
// slave is the input controller.
interface watch_input_ctrl_if;

   logic btn_mode_raw;
   logic btn_start_raw;
   logic btn_adjust_raw;
   logic mode_pulse;
   logic start_pulse;
   logic adjust_pulse;
   logic adjust_held;

   modport master (
      output btn_mode_raw, btn_start_raw, btn_adjust_raw,
      input  mode_pulse, start_pulse, adjust_pulse, adjust_held
   );

   modport slave (
      input  btn_mode_raw, btn_start_raw, btn_adjust_raw,
      output mode_pulse, start_pulse, adjust_pulse, adjust_held
   );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, ms-tick debounce counter, accepted level
// and a registered rising-edge strobe.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_MS = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ms_tick,
   input  logic btn_raw,
   output logic deb,
   output logic rise
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_MS + 1);

   logic [1:0]       sync_q, sync_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             deb_q, deb_d;
   logic             deb_prev_q, deb_prev_d;
   logic             rise_q, rise_d;
   logic             sync;

   assign sync = sync_q[1];

   always_comb begin
      sync_d     = {sync_q[0], btn_raw};
      cnt_d      = cnt_q;
      deb_d      = deb_q;
      deb_prev_d = deb_q;
      rise_d     = deb_q & ~deb_prev_q;
      // Any agreement between sync and deb restarts the stability window.
      if (sync == deb_q) begin
         cnt_d = '0;
      end else if (ms_tick) begin
         if (cnt_q >= CNT_W'(DEBOUNCE_MS - 1)) begin
            deb_d = sync;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         cnt_q      <= '0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         rise_q     <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         cnt_q      <= cnt_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         rise_q     <= rise_d;
      end
   end

   assign deb  = deb_q;
   assign rise = rise_q;

endmodule

// File: rtl/watch_input_ctrl.sv
// Watch input controller: ms prescaler, three debounced buttons, Adjust
// hold-to-repeat FSM and Mode-priority pulse arbitration.
module watch_input_ctrl
   import watch_pkg::*;
#(
   parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned HOLD_MS     = 800,
   parameter int unsigned REPEAT_MS   = 200
) (
   input  logic               clk,
   input  logic               rst_n,
   watch_input_ctrl_if.slave  io
);

   localparam int unsigned DIV    = CLK_HZ / 1000;
   localparam int unsigned DIV_W  = ms_div_w(CLK_HZ);
   localparam int unsigned HMAX   = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
   localparam int unsigned HOLD_W = $clog2(HMAX + 1);

   logic [DIV_W-1:0]  div_q, div_d;
   logic              ms_tick;
   logic              mode_deb, start_deb, adj_deb;
   logic              mode_rise, start_rise, adj_rise;
   hold_state_e       state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_nxt;
   logic              adj_req;
   logic              mode_pulse_q, mode_pulse_d;
   logic              start_pulse_q, start_pulse_d;
   logic              adjust_pulse_q, adjust_pulse_d;
   logic              adjust_held_q, adjust_held_d;

   assign ms_tick = (div_q == DIV_W'(DIV - 1));

   always_comb begin
      div_d = ms_tick ? '0 : div_q + 1'b1;
   end

   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_mode (
      .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick),
      .btn_raw(io.btn_mode_raw), .deb(mode_deb), .rise(mode_rise)
   );

   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_start (
      .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick),
      .btn_raw(io.btn_start_raw), .deb(start_deb), .rise(start_rise)
   );

   btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_adjust (
      .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick),
      .btn_raw(io.btn_adjust_raw), .deb(adj_deb), .rise(adj_rise)
   );

   assign hold_nxt = hold_cnt_q + 1'b1;

   // A request dropped because of a same-cycle Mode pulse leaves state and
   // counter untouched, so the FSM never advances on a lost pulse.
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      adj_req    = 1'b0;
      case (state_q)
         IDLE: begin
            if (adj_rise) begin
               adj_req = 1'b1;
               if (!mode_rise) begin
                  hold_cnt_d = '0;
                  state_d    = WAIT_HOLD;
               end
            end
         end
         WAIT_HOLD: begin
            if (ms_tick) begin
               if (hold_nxt >= HOLD_W'(HOLD_MS)) begin
                  adj_req = 1'b1;
                  if (!mode_rise) begin
                     hold_cnt_d = '0;
                     state_d    = REPEAT;
                  end
               end else begin
                  hold_cnt_d = hold_nxt;
               end
            end
         end
         REPEAT: begin
            if (ms_tick) begin
               if (hold_nxt >= HOLD_W'(REPEAT_MS)) begin
                  adj_req = 1'b1;
                  if (!mode_rise) begin
                     hold_cnt_d = '0;
                  end
               end else begin
                  hold_cnt_d = hold_nxt;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = '0;
         end
      endcase
      if (!adj_deb) begin
         state_d    = IDLE;
         hold_cnt_d = '0;
         adj_req    = 1'b0;
      end
   end

   always_comb begin
      mode_pulse_d   = mode_rise & mode_deb;
      start_pulse_d  = start_rise & start_deb & ~mode_pulse_d;
      adjust_pulse_d = adj_req & ~mode_pulse_d;
      adjust_held_d  = (state_q == REPEAT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q          <= '0;
         state_q        <= IDLE;
         hold_cnt_q     <= '0;
         mode_pulse_q   <= 1'b0;
         start_pulse_q  <= 1'b0;
         adjust_pulse_q <= 1'b0;
         adjust_held_q  <= 1'b0;
      end else begin
         div_q          <= div_d;
         state_q        <= state_d;
         hold_cnt_q     <= hold_cnt_d;
         mode_pulse_q   <= mode_pulse_d;
         start_pulse_q  <= start_pulse_d;
         adjust_pulse_q <= adjust_pulse_d;
         adjust_held_q  <= adjust_held_d;
      end
   end

   assign io.mode_pulse   = mode_pulse_q;
   assign io.start_pulse  = start_pulse_q;
   assign io.adjust_pulse = adjust_pulse_q;
   assign io.adjust_held  = adjust_held_q;

endmodule
